// File: rtl/keypad_hex_encoder.sv
// 4x4 hex keypad scanner: one-hot active-low column drive, 2-FF row sync,
// frame-level debounce and a two-state stable-key FSM.
module keypad_hex_encoder #(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY,
    output logic       KEY_VALID,
    output logic       KEY_HELD
);

    localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [TW-1:0] TimerLast = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CntMax    = CW'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {ResNone, ResSingle, ResMulti} res_e;
    typedef enum logic {StIdle, StPressed} state_e;

    logic [3:0]    row_meta_q, row_sync_q;
    logic [TW-1:0] timer_q;
    logic [1:0]    col_q;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]    acc_code_q, acc_code_d;
    res_e          prev_kind_q, frame_kind;
    logic [3:0]    prev_code_q;
    logic [CW-1:0] cnt_q, cnt_d;
    state_e        state_q, state_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;

    logic          sample, frame_end, hit, same;
    logic [3:0]    col_lows;
    logic [2:0]    col_n, total;
    logic [1:0]    col_row;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'h0;
            4'hD: k = 4'hF;
            4'hE: k = 4'hE;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign sample    = (timer_q == TimerLast);
    assign frame_end = sample && (col_q == 2'd3);

    // Fold the current column's low rows into the running frame tally (saturates at 2 = MULTI).
    always_comb begin
        col_lows = ~row_sync_q;
        col_n    = 3'd0;
        col_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (col_lows[r]) begin
                col_n   = col_n + 3'd1;
                col_row = 2'(r);
            end
        end
        total      = {1'b0, acc_cnt_q} + col_n;
        acc_cnt_d  = (total >= 3'd2) ? 2'd2 : total[1:0];
        acc_code_d = (acc_cnt_q == 2'd0 && col_n == 3'd1) ? key_map(col_row, col_q)
                                                          : acc_code_q;
        case (acc_cnt_d)
            2'd0:    frame_kind = ResNone;
            2'd1:    frame_kind = ResSingle;
            default: frame_kind = ResMulti;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        hit   = 1'b0;
        same  = (frame_kind == prev_kind_q) &&
                ((frame_kind != ResSingle) || (acc_code_d == prev_code_q));
        if (frame_end) begin
            if (frame_kind == ResMulti) begin
                cnt_d = '0;
            end else if (same) begin
                cnt_d = (cnt_q == CntMax) ? CntMax : cnt_q + 1'b1;
            end else begin
                cnt_d = CW'(1);
            end
            hit = (frame_kind != ResMulti) && (cnt_d == CntMax);
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        valid_d = 1'b0;
        if (hit) begin
            case (state_q)
                StIdle: begin
                    if (frame_kind == ResSingle) begin
                        state_d = StPressed;
                        key_d   = acc_code_d;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    if (frame_kind == ResSingle && acc_code_d != key_q) begin
                        key_d   = acc_code_d;
                        valid_d = 1'b1;
                    end else if (frame_kind == ResNone) begin
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            timer_q     <= '0;
            col_q       <= 2'd0;
            acc_cnt_q   <= 2'd0;
            acc_code_q  <= 4'h0;
            prev_kind_q <= ResNone;
            prev_code_q <= 4'h0;
            cnt_q       <= '0;
            state_q     <= StIdle;
            key_q       <= 4'h0;
            valid_q     <= 1'b0;
        end else begin
            row_meta_q <= ROW;
            row_sync_q <= row_meta_q;
            if (sample) begin
                timer_q <= '0;
                col_q   <= col_q + 2'd1;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
            if (frame_end) begin
                acc_cnt_q   <= 2'd0;
                acc_code_q  <= 4'h0;
                prev_kind_q <= frame_kind;
                prev_code_q <= acc_code_d;
            end else if (sample) begin
                acc_cnt_q  <= acc_cnt_d;
                acc_code_q <= acc_code_d;
            end
            cnt_q   <= cnt_d;
            state_q <= state_d;
            key_q   <= key_d;
            valid_q <= valid_d;
        end
    end

    assign COL       = ~(4'b0001 << col_q);
    assign KEY       = key_q;
    assign KEY_VALID = valid_q;
    assign KEY_HELD  = (state_q == StPressed);

endmodule

// File: tb/tb_keypad_hex_encoder.sv
// Bench for keypad_hex_encoder: keypad model, frame-level reference model and
// directed plus random press sequences.
module tb_keypad_hex_encoder;

    localparam int SD = 4;
    localparam int DF = 3;
    localparam int FR = 4 * SD;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;   // bit r*4+c

    int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    int vectors = 0;
    int errors  = 0;

    keypad_hex_encoder #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ROW       (row),
        .COL       (col),
        .KEY       (key),
        .KEY_VALID (key_valid),
        .KEY_HELD  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int         cyc = 0;
    int         tcnt = 0;
    bit         started = 0;
    int         acc_n = 0;
    int         acc_code = 0;
    int         hist [$];
    logic [3:0] exp_key = 4'h0;
    bit         exp_held = 0;
    bit         exp_valid = 0;
    logic [3:0] exp_col;
    int         pulses = 0;
    int         last_pulse_t = 0;

    task automatic end_frame();
        int  res;
        bit  uniform;
        res = (acc_n == 0) ? -1 : (acc_n == 1) ? acc_code : 16;
        acc_n = 0;
        hist.push_back(res);
        if (hist.size() > DF) void'(hist.pop_front());
        uniform = (hist.size() == DF);
        foreach (hist[i]) if (hist[i] != res) uniform = 0;
        if (uniform && res != 16) begin
            if (res >= 0) begin
                if (!exp_held || exp_key != 4'(res)) begin
                    exp_key   = 4'(res);
                    exp_held  = 1;
                    exp_valid = 1;
                end
            end else begin
                exp_held = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            tcnt++;
            exp_valid = 0;
            if (rst) begin
                cyc      = 0;
                acc_n    = 0;
                hist.delete();
                exp_key  = 4'h0;
                exp_held = 0;
                started  = 1;
            end else begin
                cyc++;
            end
            @(negedge clk);
            if (started) begin
                if (!rst) begin
                    // Row value seen during the second cycle of a window is what the DUT samples.
                    if (cyc % SD == 1) begin
                        int c;
                        c = (cyc / SD) % 4;
                        for (int r = 0; r < 4; r++) begin
                            if (pressed[r*4+c]) begin
                                acc_n++;
                                acc_code = kmap[r*4+c];
                            end
                        end
                    end
                    if (cyc % FR == 0) end_frame();
                end
                exp_col = ~(4'b0001 << ((cyc / SD) % 4));
                check_eq("col", 32'(col), 32'(exp_col));
                check_eq("key", 32'(key), 32'(exp_key));
                check_eq("key_valid", 32'(key_valid), 32'(exp_valid));
                check_eq("key_held", 32'(key_held), 32'(exp_held));
                if (key_valid === 1'b1) begin
                    pulses++;
                    last_pulse_t = tcnt;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int t0;
        int lat;
        rst     = 1'b1;
        pressed = '0;
        step(3);
        rst = 1'b0;

        // Idle scanning
        p0 = pulses;
        step(10 * FR);
        check_eq("idle_pulses", 32'(pulses - p0), 0);
        check_eq("idle_held", 32'(key_held), 0);

        // Single press of B
        p0 = pulses;
        pressed[1*4+3] = 1'b1;
        t0 = tcnt;
        step(6 * FR);
        lat = last_pulse_t - t0;
        check_eq("b_pulses", 32'(pulses - p0), 1);
        check_eq("b_key", 32'(key), 32'hB);
        check_eq("b_held", 32'(key_held), 1);
        check_eq("b_latency_ok", 32'(lat >= 48 && lat <= 67), 1);
        pressed = '0;
        step(6 * FR);
        check_eq("b_rel_held", 32'(key_held), 0);
        check_eq("b_rel_key", 32'(key), 32'hB);

        // Bouncing F
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            pressed[3*4+1] = 1'b1;
            step(5);
            pressed[3*4+1] = 1'b0;
            step(5);
        end
        pressed[3*4+1] = 1'b1;
        step(6 * FR);
        check_eq("f_pulses", 32'(pulses - p0), 1);
        check_eq("f_key", 32'(key), 32'hF);
        pressed = '0;
        step(6 * FR);

        // 7 accepted, then MULTI with 3, then 3 alone
        p0 = pulses;
        pressed[2*4+0] = 1'b1;
        step(6 * FR);
        check_eq("seven_pulses", 32'(pulses - p0), 1);
        check_eq("seven_key", 32'(key), 32'h7);
        p0 = pulses;
        pressed[0*4+2] = 1'b1;
        step(10 * FR);
        check_eq("multi_pulses", 32'(pulses - p0), 0);
        check_eq("multi_key", 32'(key), 32'h7);
        check_eq("multi_held", 32'(key_held), 1);
        pressed[2*4+0] = 1'b0;
        step(6 * FR);
        check_eq("three_pulses", 32'(pulses - p0), 1);
        check_eq("three_key", 32'(key), 32'h3);
        pressed = '0;
        step(6 * FR);

        // Slide 1 -> 9 without release
        p0 = pulses;
        pressed[0] = 1'b1;
        step(6 * FR);
        check_eq("one_key", 32'(key), 32'h1);
        pressed[0] = 1'b0;
        pressed[2*4+2] = 1'b1;
        step(6 * FR);
        check_eq("slide_pulses", 32'(pulses - p0), 2);
        check_eq("slide_key", 32'(key), 32'h9);
        check_eq("slide_held", 32'(key_held), 1);
        pressed = '0;
        step(6 * FR);

        // Key 0 held through a mid-frame reset
        pressed[3*4+0] = 1'b1;
        step(6 * FR);
        check_eq("zero_key", 32'(key), 32'h0);
        step(7);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check_eq("rst_col", 32'(col), 32'hE);
        check_eq("rst_key", 32'(key), 32'h0);
        check_eq("rst_held", 32'(key_held), 0);
        p0 = pulses;
        step(6 * FR);
        check_eq("rst_pulses", 32'(pulses - p0), 1);
        check_eq("rst_rekey", 32'(key), 32'h0);
        pressed = '0;
        step(6 * FR);

        // Random presses, releases, bounces and chords
        for (int it = 0; it < 30; it++) begin
            int mode;
            logic [15:0] nxt;
            mode = $urandom_range(0, 9);
            nxt  = '0;
            if (mode >= 2) nxt[$urandom_range(0, 15)] = 1'b1;
            if (mode >= 8) nxt[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                for (int b = 0; b < 2; b++) begin
                    pressed = nxt;
                    step($urandom_range(1, 6));
                    pressed = '0;
                    step($urandom_range(1, 6));
                end
            end
            pressed = nxt;
            step($urandom_range(1, 5) * FR + $urandom_range(0, FR - 1));
        end
        pressed = '0;
        step(6 * FR);
        check_eq("final_held", 32'(key_held), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
